// File: rtl/sm_dm_arbiter_if.sv
// Bus bundles for the data-memory arbiter: a core-side port (with error flag)
// and a memory-side port. The master modport is the side that issues requests.
interface sm_dm_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, addr, we, wdata, input rdata, ack, err);
  modport slave  (input req, addr, we, wdata, output rdata, ack, err);
endinterface

interface sm_dm_mem_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, addr, we, wdata, input rdata, ack);
  modport slave  (input req, addr, we, wdata, output rdata, ack);
endinterface

// File: rtl/sm_dm_arbiter.sv
// Two-core round-robin arbiter onto one data-memory port, with registered
// slave-side signals, a one-cycle ack per access and a slave-response timeout.
module sm_dm_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic           clk,
  input  logic           rst,
  sm_dm_arbiter_if.slave m0,
  sm_dm_arbiter_if.slave m1,
  sm_dm_mem_if.master    s
);
  // IDLE: arbitrate | BUSY: s_req held, wait s_ack or timeout | RESP: ack winner
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state_q;
  logic        gnt_id_q;
  logic        last_grant_q;
  logic [15:0] cnt_q;
  logic        s_req_q;
  logic        s_we_q;
  logic [31:0] s_addr_q;
  logic [31:0] s_wdata_q;
  logic        m0_ack_q;
  logic        m1_ack_q;
  logic        m0_err_q;
  logic        m1_err_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  logic        gnt_valid_d;
  logic        gnt_id_d;
  logic        done_d;
  logic        err_d;
  logic [31:0] resp_d;

  always_comb begin
    gnt_valid_d = m0.req | m1.req;
    if (m0.req && m1.req) gnt_id_d = ~last_grant_q;
    else                  gnt_id_d = m1.req;

    // s_ack takes precedence over a timeout landing in the same cycle
    done_d = 1'b0;
    err_d  = 1'b0;
    resp_d = '0;
    if (s.ack) begin
      done_d = 1'b1;
      resp_d = s_we_q ? 32'd0 : s.rdata;
    end else if (TO_EN && (cnt_q == TO_LAST)) begin
      done_d = 1'b1;
      err_d  = 1'b1;
      resp_d = ERR_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      s_req_q      <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            gnt_id_q  <= gnt_id_d;
            s_addr_q  <= gnt_id_d ? m1.addr  : m0.addr;
            s_we_q    <= gnt_id_d ? m1.we    : m0.we;
            s_wdata_q <= gnt_id_d ? m1.wdata : m0.wdata;
            cnt_q     <= '0;
            s_req_q   <= 1'b1;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (done_d) begin
            s_req_q <= 1'b0;
            state_q <= RESP;
            if (gnt_id_q) begin
              m1_ack_q   <= 1'b1;
              m1_rdata_q <= resp_d;
              m1_err_q   <= err_d;
            end else begin
              m0_ack_q   <= 1'b1;
              m0_rdata_q <= resp_d;
              m0_err_q   <= err_d;
            end
          end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          last_grant_q <= gnt_id_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s.req     = s_req_q;
  assign s.addr    = s_addr_q;
  assign s.we      = s_we_q;
  assign s.wdata   = s_wdata_q;
  assign m0.ack    = m0_ack_q;
  assign m0.rdata  = m0_rdata_q;
  assign m0.err    = m0_err_q;
  assign m1.ack    = m1_ack_q;
  assign m1.rdata  = m1_rdata_q;
  assign m1.err    = m1_err_q;
endmodule

// File: tb/tb_sm_dm_arbiter.sv
// Directed bench for sm_dm_arbiter: instance A uses TIMEOUT=4, instance B
// uses TIMEOUT=3 for the ack-versus-timeout boundary.
module tb_sm_dm_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  sm_dm_arbiter_if c0_a ();
  sm_dm_arbiter_if c1_a ();
  sm_dm_arbiter_if c0_b ();
  sm_dm_arbiter_if c1_b ();
  sm_dm_mem_if     mem_a ();
  sm_dm_mem_if     mem_b ();

  sm_dm_arbiter #(.TIMEOUT(4)) u_dut_a (
    .clk (clk), .rst (rst), .m0 (c0_a), .m1 (c1_a), .s (mem_a)
  );
  sm_dm_arbiter #(.TIMEOUT(3)) u_dut_b (
    .clk (clk), .rst (rst), .m0 (c0_b), .m1 (c1_b), .s (mem_b)
  );

  int          slv_ack_cyc [2];
  logic [31:0] slv_rdata [2];
  int          busy_a;
  int          busy_b;

  // slave models: ack in the Nth cycle of s_req (0 = never)
  initial begin
    mem_a.ack = 1'b0; mem_a.rdata = '0; busy_a = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_a.req) begin
        busy_a++;
        mem_a.ack   = (busy_a == slv_ack_cyc[0]);
        mem_a.rdata = slv_rdata[0];
      end else begin
        busy_a = 0; mem_a.ack = 1'b0;
      end
    end
  end

  initial begin
    mem_b.ack = 1'b0; mem_b.rdata = '0; busy_b = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_b.req) begin
        busy_b++;
        mem_b.ack   = (busy_b == slv_ack_cyc[1]);
        mem_b.rdata = slv_rdata[1];
      end else begin
        busy_b = 0; mem_b.ack = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit b, input bit id, input bit req, input logic [31:0] addr,
                       input bit we, input logic [31:0] wd);
    case ({b, id})
      2'b00: begin c0_a.req = req; c0_a.addr = addr; c0_a.we = we; c0_a.wdata = wd; end
      2'b01: begin c1_a.req = req; c1_a.addr = addr; c1_a.we = we; c1_a.wdata = wd; end
      2'b10: begin c0_b.req = req; c0_b.addr = addr; c0_b.we = we; c0_b.wdata = wd; end
      default: begin c1_b.req = req; c1_b.addr = addr; c1_b.we = we; c1_b.wdata = wd; end
    endcase
  endtask

  task automatic sample_core(input bit b, input bit id, output bit ack,
                             output logic [31:0] rd, output bit err);
    case ({b, id})
      2'b00: begin ack = c0_a.ack; rd = c0_a.rdata; err = c0_a.err; end
      2'b01: begin ack = c1_a.ack; rd = c1_a.rdata; err = c1_a.err; end
      2'b10: begin ack = c0_b.ack; rd = c0_b.rdata; err = c0_b.err; end
      default: begin ack = c1_b.ack; rd = c1_b.rdata; err = c1_b.err; end
    endcase
  endtask

  task automatic sample_mem(input bit b, output bit req, output logic [31:0] addr,
                            output bit we, output logic [31:0] wd);
    if (!b) begin req = mem_a.req; addr = mem_a.addr; we = mem_a.we; wd = mem_a.wdata; end
    else    begin req = mem_b.req; addr = mem_b.addr; we = mem_b.we; wd = mem_b.wdata; end
  endtask

  // one request from core id; returns response, negedges to ack, s_req cycles
  // and count of s_req cycles whose bus did not match the request
  task automatic txn(input bit b, input bit id, input logic [31:0] addr, input bit we,
                     input logic [31:0] wd, input int ack_cyc, input logic [31:0] sd,
                     output logic [31:0] rd, output bit err, output int lat,
                     output int busy_n, output int bad_bus);
    bit a, r, w, e;
    logic [31:0] ad, d, x;
    slv_ack_cyc[b] = ack_cyc;
    slv_rdata[b]   = sd;
    drive(b, id, 1'b1, addr, we, wd);
    a = 1'b0; rd = '0; err = 1'b0; lat = 0; busy_n = 0; bad_bus = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      sample_mem(b, r, ad, w, d);
      if (r) begin
        busy_n++;
        if (ad !== addr || w !== we || d !== wd) bad_bus++;
      end
      sample_core(b, id, a, x, e);
      if (a) begin
        rd = x; err = e;
        break;
      end
    end
    check("txn_ack_seen", {31'd0, a}, 32'd1);
    drive(b, id, 1'b0, addr, we, wd);
  endtask

  logic [31:0] rd, r0, r1;
  bit          er, any_ack, seen_first, two_acks, long_ack, p0, p1;
  int          lat, bn, bb;
  int          order_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(i[1], i[0], 1'b0, '0, 1'b0, '0);
    slv_ack_cyc[0] = 0; slv_ack_cyc[1] = 0;
    slv_rdata[0] = '0;  slv_rdata[1] = '0;
    repeat (2) @(negedge clk);
    check("rst_s_req",    mem_a.req,   0);
    check("rst_s_addr",   mem_a.addr,  0);
    check("rst_m0_ack",   c0_a.ack,    0);
    check("rst_m1_ack",   c1_a.ack,    0);
    check("rst_m0_rdata", c0_a.rdata,  0);
    check("rst_m1_err",   c1_a.err,    0);
    rst = 1'b0;
    @(negedge clk);

    // single read, zero-wait slave
    txn(0, 0, 32'h10, 0, 32'h0, 1, 32'h12345678, rd, er, lat, bn, bb);
    check("rd_data",    rd,  32'h12345678);
    check("rd_err",     er,  0);
    check("rd_latency", lat, 2);
    check("rd_busy",    bn,  1);
    check("rd_bus",     bb,  0);
    @(negedge clk);
    check("rd_ack_one_cycle", c0_a.ack,  0);
    check("rd_s_req_idle",    mem_a.req, 0);

    // asynchronous reset during an m0 write
    slv_ack_cyc[0] = 0;
    drive(0, 0, 1'b1, 32'h20, 1'b1, 32'h55);
    @(negedge clk);
    check("mid_s_req", mem_a.req, 1);
    check("mid_s_we",  mem_a.we,  1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_s_req",  mem_a.req,  0);
    check("mid_rst_s_addr", mem_a.addr, 0);
    drive(0, 0, 1'b0, 32'h20, 1'b1, 32'h55);
    any_ack = 1'b0;
    repeat (2) begin @(negedge clk); any_ack |= c0_a.ack | c1_a.ack; end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); any_ack |= c0_a.ack | c1_a.ack; end
    check("mid_no_ack", any_ack, 0);
    txn(0, 1, 32'h30, 0, 32'h0, 1, 32'hCAFE0001, rd, er, lat, bn, bb);
    check("post_rst_m1_data", rd,  32'hCAFE0001);
    check("post_rst_m1_err",  er,  0);
    check("post_rst_m1_lat",  lat, 2);

    // simultaneous requests after reset: core 0 first
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    slv_ack_cyc[0] = 1; slv_rdata[0] = 32'h11112222;
    drive(0, 0, 1'b1, 32'h4, 1'b1, 32'hAAAA);
    drive(0, 1, 1'b1, 32'h8, 1'b0, 32'h0);
    seen_first = 1'b0; r0 = '0; r1 = '0;
    order_q.delete();
    for (int i = 0; i < 20 && order_q.size() < 2; i++) begin
      @(negedge clk);
      if (mem_a.req && !seen_first) begin
        seen_first = 1'b1;
        check("sim_first_addr",  mem_a.addr,  32'h4);
        check("sim_first_we",    mem_a.we,    1);
        check("sim_first_wdata", mem_a.wdata, 32'hAAAA);
      end
      if (c0_a.ack) begin order_q.push_back(0); r0 = c0_a.rdata; c0_a.req = 1'b0; end
      if (c1_a.ack) begin order_q.push_back(1); r1 = c1_a.rdata; c1_a.req = 1'b0; end
    end
    check("sim_ack_count", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check("sim_order_0", order_q[0], 0);
      check("sim_order_1", order_q[1], 1);
    end
    check("sim_m0_wr_rdata", r0, 32'h0);
    check("sim_m1_rdata",    r1, 32'h11112222);

    // continuous contention: strict alternation
    @(negedge clk);
    slv_ack_cyc[0] = 1; slv_rdata[0] = 32'h77;
    drive(0, 0, 1'b1, 32'h100, 1'b0, 32'h0);
    drive(0, 1, 1'b1, 32'h200, 1'b0, 32'h0);
    order_q.delete();
    two_acks = 1'b0; long_ack = 1'b0; p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 60 && order_q.size() < 8; i++) begin
      @(negedge clk);
      if (c0_a.ack && c1_a.ack) two_acks = 1'b1;
      if ((p0 && c0_a.ack) || (p1 && c1_a.ack)) long_ack = 1'b1;
      p0 = c0_a.ack; p1 = c1_a.ack;
      if (c0_a.ack) order_q.push_back(0);
      if (c1_a.ack) order_q.push_back(1);
    end
    c0_a.req = 1'b0; c1_a.req = 1'b0;
    check("rr_count", order_q.size(), 8);
    for (int i = 0; i < order_q.size(); i++)
      check($sformatf("rr_grant_%0d", i), order_q[i], i % 2);
    check("rr_two_acks", two_acks, 0);
    check("rr_long_ack", long_ack, 0);
    repeat (2) @(negedge clk);

    // timeout on instance A (TIMEOUT=4)
    txn(0, 1, 32'h40, 0, 32'h0, 0, 32'h0, rd, er, lat, bn, bb);
    check("to_rdata", rd,  32'hDEADBEEF);
    check("to_err",   er,  1);
    check("to_busy",  bn,  4);
    check("to_lat",   lat, 5);
    check("to_bus",   bb,  0);
    @(negedge clk);
    txn(0, 1, 32'h44, 0, 32'h0, 2, 32'h0BADF00D, rd, er, lat, bn, bb);
    check("after_to_rdata", rd, 32'h0BADF00D);
    check("after_to_err",   er, 0);
    check("after_to_busy",  bn, 2);

    // instance B (TIMEOUT=3): ack in the last allowed cycle wins
    @(negedge clk);
    txn(1, 0, 32'h50, 0, 32'h0, 3, 32'h600DF00D, rd, er, lat, bn, bb);
    check("ws_rdata", rd, 32'h600DF00D);
    check("ws_err",   er, 0);
    check("ws_busy",  bn, 3);
    check("ws_addr_stable", bb, 0);
    @(negedge clk);
    txn(1, 1, 32'h54, 1, 32'h99, 0, 32'h0, rd, er, lat, bn, bb);
    check("b_to_rdata", rd, 32'hDEADBEEF);
    check("b_to_err",   er, 1);
    check("b_to_busy",  bn, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
